// File: rtl/nes_pad_scanner.sv
// Multi-pad NES controller scanner: shared latch/pulse, per-pad serial capture, held/press/code outputs.
// Optional macro AUTO_REPEAT_EN adds per-pad auto-repeat of held buttons.
module nes_pad_scanner #(
    parameter int CLK_HZ    = 50000000,
    parameter int POLL_HZ   = 60,
    parameter int LATCH_CYC = 600,
    parameter int PULSE_CYC = 600,
    parameter int NUM_PADS  = 2,
    parameter int NUM_BITS  = 8
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REP_DELAY = 20,
    parameter int REP_RATE  = 6
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PADS-1:0]          pad_data,
    output logic                         pad_latch,
    output logic                         pad_pulse,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] press,
    output logic [NUM_PADS*4-1:0]        code,
    output logic                         frame_valid,
    output logic                         game_start
);

    localparam int POLL_DIV = CLK_HZ / POLL_HZ;
    localparam int TW       = $clog2(POLL_DIV);
    localparam int CMAX     = (LATCH_CYC > PULSE_CYC) ? LATCH_CYC : PULSE_CYC;
    localparam int CW       = $clog2(CMAX);
    localparam int BW       = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int NB       = NUM_PADS * NUM_BITS;

    localparam logic [TW-1:0] TICK_LAST  = TW'(POLL_DIV - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(LATCH_CYC / 2 - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] PULSE_HIGH = CW'(PULSE_CYC / 2);
    localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_GAP, S_SHIFT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [NUM_PADS-1:0]    sync_q, sync_d;
    logic [NB-1:0]          samp_q, samp_d;
    logic                   latch_q, latch_d;
    logic                   pulse_q, pulse_d;
    logic [NB-1:0]          buttons_q, buttons_d;
    logic [NB-1:0]          press_q, press_d;
    logic [NUM_PADS*4-1:0]  code_q, code_d;
    logic                   fv_q, fv_d;
    logic                   game_q, game_d;
    logic                   do_sample;
    logic                   frame_end;
    logic [BW-1:0]          bit_sel;

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REP_DELAY + 1);
    localparam logic [RW-1:0] REP_LAST   = RW'(REP_DELAY);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REP_DELAY - REP_RATE);
    logic [RW-1:0] rep_q [NUM_PADS];
    logic [RW-1:0] rep_d [NUM_PADS];
    logic [RW-1:0] rep_next;
`endif

    always_comb begin
        state_d   = state_q;
        tick_d    = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sync_d    = pad_data;
        samp_d    = samp_q;
        latch_d   = latch_q;
        pulse_d   = pulse_q;
        buttons_d = buttons_q;
        press_d   = '0;
        code_d    = code_q;
        fv_d      = 1'b0;
        game_d    = game_q;
        do_sample = 1'b0;
        frame_end = 1'b0;
        bit_sel   = bit_q;
`ifdef AUTO_REPEAT_EN
        rep_d     = rep_q;
        rep_next  = '0;
`endif

        case (state_q)
            S_IDLE: begin
                // A poll tick arriving mid-frame is simply ignored since only IDLE looks at it.
                if (tick_q == TICK_LAST) begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                    latch_d = 1'b1;
                end
            end
            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    latch_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    do_sample = 1'b1;
                    bit_sel   = '0;
                    if (NUM_BITS == 1) begin
                        frame_end = 1'b1;
                    end else begin
                        state_d = S_SHIFT;
                        cnt_d   = '0;
                        bit_d   = BW'(1);
                        pulse_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHIFT: begin
                if (cnt_q == PULSE_LAST) begin
                    do_sample = 1'b1;
                    if (bit_q == BIT_LAST) begin
                        frame_end = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        bit_d   = bit_q + BW'(1);
                        pulse_d = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    pulse_d = (cnt_q + CW'(1)) < PULSE_HIGH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_sample) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                for (int k = 0; k < NUM_BITS; k++) begin
                    if (bit_sel == BW'(k)) samp_d[p*NUM_BITS+k] = sync_q[p];
                end
            end
        end

        // The last sample and the frame results are taken on the same edge, so outputs are live in DONE.
        if (frame_end) begin
            state_d   = S_DONE;
            cnt_d     = '0;
            bit_d     = '0;
            pulse_d   = 1'b0;
            fv_d      = 1'b1;
            buttons_d = ~samp_d;
            press_d   = buttons_d & ~buttons_q;
`ifdef AUTO_REPEAT_EN
            for (int p = 0; p < NUM_PADS; p++) begin
                if ((buttons_d[p*NUM_BITS +: NUM_BITS] != '0) &&
                    (buttons_d[p*NUM_BITS +: NUM_BITS] == buttons_q[p*NUM_BITS +: NUM_BITS])) begin
                    rep_next = rep_q[p] + RW'(1);
                    if (rep_next == REP_LAST) begin
                        rep_d[p] = REP_RELOAD;
                        press_d[p*NUM_BITS +: NUM_BITS] = buttons_d[p*NUM_BITS +: NUM_BITS];
                    end else begin
                        rep_d[p] = rep_next;
                    end
                end else begin
                    rep_d[p] = '0;
                end
            end
`endif
            for (int p = 0; p < NUM_PADS; p++) begin
                code_d[p*4 +: 4] = 4'd0;
                for (int k = NUM_BITS - 1; k >= 0; k--) begin
                    if (press_d[p*NUM_BITS+k]) code_d[p*4 +: 4] = 4'(k + 1);
                end
            end
            for (int k = 0; k < NUM_BITS; k++) begin
                if (k == 3) game_d = game_q | press_d[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            sync_q    <= '0;
            samp_q    <= '0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            buttons_q <= '0;
            press_q   <= '0;
            code_q    <= '0;
            fv_q      <= 1'b0;
            game_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
            for (int p = 0; p < NUM_PADS; p++) rep_q[p] <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sync_q    <= sync_d;
            samp_q    <= samp_d;
            latch_q   <= latch_d;
            pulse_q   <= pulse_d;
            buttons_q <= buttons_d;
            press_q   <= press_d;
            code_q    <= code_d;
            fv_q      <= fv_d;
            game_q    <= game_d;
`ifdef AUTO_REPEAT_EN
            for (int p = 0; p < NUM_PADS; p++) rep_q[p] <= rep_d[p];
`endif
        end
    end

    assign pad_latch   = latch_q;
    assign pad_pulse   = pulse_q;
    assign buttons     = buttons_q;
    assign press       = press_q;
    assign code        = code_q;
    assign frame_valid = fv_q;
    assign game_start  = game_q;

endmodule

// File: tb/tb_nes_pad_scanner.sv
// Directed bench for nes_pad_scanner (POLL_DIV=100, LATCH_CYC=4, PULSE_CYC=4, two 8-bit pads).
module tb_nes_pad_scanner;
    localparam int NP = 2;
    localparam int NBIT = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NP-1:0]   pad_data;
    logic            pad_latch;
    logic            pad_pulse;
    logic [15:0]     buttons;
    logic [15:0]     press;
    logic [7:0]      code;
    logic            frame_valid;
    logic            game_start;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nes_pad_scanner #(
        .CLK_HZ(1000), .POLL_HZ(10), .LATCH_CYC(4), .PULSE_CYC(4), .NUM_PADS(NP), .NUM_BITS(NBIT)
    ) dut (
        .clk(clk), .reset(reset), .pad_data(pad_data), .pad_latch(pad_latch), .pad_pulse(pad_pulse),
        .buttons(buttons), .press(press), .code(code), .frame_valid(frame_valid), .game_start(game_start)
    );

    // Behavioural NES pads: latch reloads, each rising pulse advances to the next button.
    logic [7:0] tb_btn [NP];
    int         pidx [NP];
    logic       pulse_prev = 1'b0;

    initial begin
        tb_btn[0] = 8'h00;
        tb_btn[1] = 8'h00;
        pidx[0] = 8;
        pidx[1] = 8;
    end

    always @(posedge clk) begin
        pulse_prev <= pad_pulse;
        for (int p = 0; p < NP; p++) begin
            if (pad_latch) pidx[p] <= 0;
            else if (pad_pulse && !pulse_prev && pidx[p] < 8) pidx[p] <= pidx[p] + 1;
        end
    end

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            pad_data[p] = (pidx[p] < 8) ? ~tb_btn[p][pidx[p]] : 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for n edges; on return the current cycle is cycle 0 after release.
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic wait_fv(input int limit, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (frame_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (pad_latch !== 1'b0) begin errors++; $display("FAIL reset_latch got=%b exp=0", pad_latch); end
        checks++; if (pad_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", pad_pulse); end
        checks++; if (buttons !== 16'h0) begin errors++; $display("FAIL reset_buttons got=%h exp=0000", buttons); end
        checks++; if (press !== 16'h0) begin errors++; $display("FAIL reset_press got=%h exp=0000", press); end
        checks++; if (code !== 8'h0) begin errors++; $display("FAIL reset_code got=%h exp=00", code); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
        checks++; if (game_start !== 1'b0) begin errors++; $display("FAIL reset_game got=%b exp=0", game_start); end
        reset = 1'b0;
    endtask

    task automatic test_idle_frame();
        int latch_rise = -1;
        int latch_hi = 0;
        int pulses = 0;
        int fv_cyc = -1;
        int fv_n = 0;
        logic prev = 1'b0;
        logic [15:0] b_at = 16'hxxxx;
        logic [7:0]  c_at = 8'hxx;
        for (int c = 1; c <= 140; c++) begin
            step();
            if (pad_latch) begin
                latch_hi++;
                if (latch_rise < 0) latch_rise = c;
            end
            if (pad_pulse && !prev) pulses++;
            prev = pad_pulse;
            if (frame_valid) begin
                fv_n++;
                fv_cyc = c;
                b_at = buttons;
                c_at = code;
            end
        end
        checks++; if (latch_rise != 100) begin errors++; $display("FAIL idle_latch_start got=%0d exp=100", latch_rise); end
        checks++; if (latch_hi != 4) begin errors++; $display("FAIL idle_latch_len got=%0d exp=4", latch_hi); end
        checks++; if (pulses != 7) begin errors++; $display("FAIL idle_pulses got=%0d exp=7", pulses); end
        checks++; if (fv_cyc != 134) begin errors++; $display("FAIL idle_fv_cycle got=%0d exp=134", fv_cyc); end
        checks++; if (fv_n != 1) begin errors++; $display("FAIL idle_fv_count got=%0d exp=1", fv_n); end
        checks++; if (b_at !== 16'h0) begin errors++; $display("FAIL idle_buttons got=%h exp=0000", b_at); end
        checks++; if (c_at !== 8'h0) begin errors++; $display("FAIL idle_code got=%h exp=00", c_at); end
    endtask

    task automatic test_press_a();
        bit to;
        tb_btn[0] = 8'h01;
        wait_fv(200, to);
        checks++; if (to) begin errors++; $display("FAIL a_timeout got=timeout exp=frame_valid"); end
        checks++; if (buttons !== 16'h0001) begin errors++; $display("FAIL a_buttons got=%h exp=0001", buttons); end
        checks++; if (press !== 16'h0001) begin errors++; $display("FAIL a_press got=%h exp=0001", press); end
        checks++; if (code !== 8'h01) begin errors++; $display("FAIL a_code got=%h exp=01", code); end
        step();
        checks++; if (press !== 16'h0) begin errors++; $display("FAIL a_press_strobe got=%h exp=0000", press); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL a_fv_strobe got=%b exp=0", frame_valid); end
        checks++; if (code !== 8'h01) begin errors++; $display("FAIL a_code_hold got=%h exp=01", code); end
        wait_fv(200, to);
        checks++; if (to) begin errors++; $display("FAIL a2_timeout got=timeout exp=frame_valid"); end
        checks++; if (press !== 16'h0) begin errors++; $display("FAIL a2_press got=%h exp=0000", press); end
        checks++; if (buttons !== 16'h0001) begin errors++; $display("FAIL a2_buttons got=%h exp=0001", buttons); end
        checks++; if (code !== 8'h00) begin errors++; $display("FAIL a2_code got=%h exp=00", code); end
        checks++; if (game_start !== 1'b0) begin errors++; $display("FAIL a2_game got=%b exp=0", game_start); end
    endtask

    task automatic test_pad1_multi();
        bit to;
        tb_btn[0] = 8'h00;
        tb_btn[1] = 8'h50;
        wait_fv(200, to);
        checks++; if (to) begin errors++; $display("FAIL p1_timeout got=timeout exp=frame_valid"); end
        checks++; if (buttons !== 16'h5000) begin errors++; $display("FAIL p1_buttons got=%h exp=5000", buttons); end
        checks++; if (press !== 16'h5000) begin errors++; $display("FAIL p1_press got=%h exp=5000", press); end
        checks++; if (code !== 8'h50) begin errors++; $display("FAIL p1_code got=%h exp=50", code); end
    endtask

    task automatic test_back_to_back();
        bit to;
        tb_btn[1] = 8'h00;
        wait_fv(200, to);
        checks++; if (to) begin errors++; $display("FAIL rel_timeout got=timeout exp=frame_valid"); end
        checks++; if (buttons !== 16'h0) begin errors++; $display("FAIL rel_buttons got=%h exp=0000", buttons); end
        tb_btn[1] = 8'h50;
        wait_fv(200, to);
        checks++; if (to) begin errors++; $display("FAIL rep_timeout got=timeout exp=frame_valid"); end
        checks++; if (press !== 16'h5000) begin errors++; $display("FAIL repress_press got=%h exp=5000", press); end
        tb_btn[0] = 8'h0C;
        tb_btn[1] = 8'hD0;
        wait_fv(200, to);
        checks++; if (to) begin errors++; $display("FAIL both_timeout got=timeout exp=frame_valid"); end
        checks++; if (buttons !== 16'hD00C) begin errors++; $display("FAIL both_buttons got=%h exp=d00c", buttons); end
        checks++; if (press !== 16'h800C) begin errors++; $display("FAIL both_press got=%h exp=800c", press); end
        checks++; if (code !== 8'h83) begin errors++; $display("FAIL both_code got=%h exp=83", code); end
        checks++; if (game_start !== 1'b1) begin errors++; $display("FAIL both_game got=%b exp=1", game_start); end
    endtask

    task automatic test_game_start_sticky();
        bit to;
        tb_btn[0] = 8'h00;
        tb_btn[1] = 8'h00;
        wait_fv(200, to);
        checks++; if (to) begin errors++; $display("FAIL gs_timeout got=timeout exp=frame_valid"); end
        checks++; if (buttons !== 16'h0) begin errors++; $display("FAIL gs_buttons got=%h exp=0000", buttons); end
        checks++; if (game_start !== 1'b1) begin errors++; $display("FAIL gs_sticky got=%b exp=1", game_start); end
        do_reset(2);
        checks++; if (game_start !== 1'b0) begin errors++; $display("FAIL gs_reset got=%b exp=0", game_start); end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        bit seen = 1'b0;
        int fv_n = 0;
        int latch_rise = -1;
        tb_btn[0] = 8'hFF;
        for (int i = 0; i < 200; i++) begin
            step();
            if (pad_latch) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_latch_timeout got=none exp=latch"); end
        repeat (10) step();
        checks++; if (pad_pulse !== 1'b1) begin errors++; $display("FAIL mid_pulse_before got=%b exp=1", pad_pulse); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (pad_pulse !== 1'b0) begin errors++; $display("FAIL mid_pulse_after got=%b exp=0", pad_pulse); end
        checks++; if (pad_latch !== 1'b0) begin errors++; $display("FAIL mid_latch_after got=%b exp=0", pad_latch); end
        for (int c = 1; c <= 100; c++) begin
            step();
            if (frame_valid) fv_n++;
            if (pad_latch && latch_rise < 0) latch_rise = c;
        end
        checks++; if (fv_n != 0) begin errors++; $display("FAIL mid_no_fv got=%0d exp=0", fv_n); end
        checks++; if (latch_rise != 100) begin errors++; $display("FAIL mid_next_latch got=%0d exp=100", latch_rise); end
        wait_fv(200, to);
        checks++; if (to) begin errors++; $display("FAIL mid2_timeout got=timeout exp=frame_valid"); end
        checks++; if (press !== 16'h00FF) begin errors++; $display("FAIL mid2_press got=%h exp=00ff", press); end
        checks++; if (code !== 8'h01) begin errors++; $display("FAIL mid2_code got=%h exp=01", code); end
        checks++; if (game_start !== 1'b1) begin errors++; $display("FAIL mid2_game got=%b exp=1", game_start); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_idle_frame();
        test_press_a();
        test_pad1_multi();
        test_back_to_back();
        test_game_start_sticky();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
